riscv_npc: RTL

RISCV_NPC -- requirements
Module: riscv_npc

---
 rtl/riscv_defs.sv | 25 ++
 rtl/riscv_npc_ras.sv | 32 +++
 rtl/riscv_npc.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/riscv_defs.sv
// rtl/riscv_defs.sv - shared constants for the next-PC predictor
package riscv_defs;

   typedef enum logic [1:0] {
      BTB_COND = 2'd0,
      BTB_CALL = 2'd1,
      BTB_RET  = 2'd2,
      BTB_JMP  = 2'd3
   } btb_type_t;

   localparam logic [1:0] BHT_INIT = 2'b01;

   // Call outranks ret so a combined call/return is tracked as a call.
   function automatic btb_type_t btb_type_encode(input logic is_call,
                                                 input logic is_ret,
                                                 input logic is_jmp);
      btb_type_t t;
      if (is_call)      t = BTB_CALL;
      else if (is_ret)  t = BTB_RET;
      else if (is_jmp)  t = BTB_JMP;
      else              t = BTB_COND;
      return t;
   endfunction

endpackage

// File: rtl/riscv_npc_ras.sv
// rtl/riscv_npc_ras.sv - circular return-address stack, overflow overwrites oldest
module riscv_npc_ras #(
   parameter int DEPTH = 8
) (
   input  logic        clk_i,
   input  logic        flush,
   input  logic        push,
   input  logic [31:0] push_addr,
   input  logic        pop,
   output logic [31:0] top
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]      stack [DEPTH];
   logic [PTR_W-1:0] ptr;

   always_ff @(posedge clk_i) begin
      if (flush) begin
         ptr <= '0;
      end else if (push) begin
         stack[ptr] <= push_addr;
         ptr        <= ptr + PTR_W'(1);
      end else if (pop) begin
         ptr <= ptr - PTR_W'(1);
      end
   end

   // ptr points at the next free slot; underflow simply wraps onto stale data.
   assign top = stack[ptr - PTR_W'(1)];

endmodule

// File: rtl/riscv_npc.sv
// rtl/riscv_npc.sv - BTB/BHT next-PC predictor; NPC_RAS_EN adds a return-address stack
module riscv_npc
   import riscv_defs::*;
#(
   parameter int NUM_BTB_ENTRIES = 16,
   parameter int NUM_BHT_ENTRIES = 64,
   parameter int NUM_RAS_ENTRIES = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        invalidate_i,
   input  logic        branch_request_i,
   input  logic        branch_is_taken_i,
   input  logic        branch_is_not_taken_i,
   input  logic [31:0] branch_source_i,
   input  logic [31:0] branch_pc_i,
   input  logic        branch_is_call_i,
   input  logic        branch_is_ret_i,
   input  logic        branch_is_jmp_i,
   input  logic [31:0] pc_f_i,
   output logic [31:0] next_pc_f_o,
   output logic        next_taken_f_o
);

   localparam int BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);
   localparam int BHT_IDX_W = $clog2(NUM_BHT_ENTRIES);

   logic [NUM_BTB_ENTRIES-1:0] btb_valid;
   logic [29:0]                btb_tag    [NUM_BTB_ENTRIES];
   logic [31:0]                btb_target [NUM_BTB_ENTRIES];
   btb_type_t                  btb_type   [NUM_BTB_ENTRIES];
   logic [1:0]                 bht        [NUM_BHT_ENTRIES];
   logic [BTB_IDX_W-1:0]       alloc_ptr;

   logic                 flush;
   logic                 upd_taken;
   logic                 upd_not_taken;
   logic                 lk_hit;
   logic                 upd_hit;
   logic [BTB_IDX_W-1:0] lk_idx;
   logic [BTB_IDX_W-1:0] upd_idx;
   logic [BTB_IDX_W-1:0] wr_idx;
   logic [BHT_IDX_W-1:0] lk_bht_idx;
   logic [BHT_IDX_W-1:0] upd_bht_idx;
   logic [31:0]          seq_pc;
   logic [31:0]          pred_target;
   logic                 pred_taken;
   btb_type_t            upd_type;
   logic                 unused_low_bits;

   assign flush         = rst_i | invalidate_i;
   assign upd_taken     = branch_request_i & branch_is_taken_i;
   assign upd_not_taken = branch_request_i & branch_is_not_taken_i & ~branch_is_taken_i;
   assign lk_bht_idx    = pc_f_i[BHT_IDX_W+1:2];
   assign upd_bht_idx   = branch_source_i[BHT_IDX_W+1:2];
   assign seq_pc        = {pc_f_i[31:2], 2'b00} + 32'd4;
   assign upd_type      = btb_type_encode(branch_is_call_i, branch_is_ret_i, branch_is_jmp_i);
   assign wr_idx        = upd_hit ? upd_idx : alloc_ptr;
   assign unused_low_bits = ^{pc_f_i[1:0], branch_source_i[1:0]};

   // Entries are only allocated on a miss, so at most one entry can match.
   always_comb begin
      lk_hit  = 1'b0;
      lk_idx  = '0;
      upd_hit = 1'b0;
      upd_idx = '0;
      for (int i = NUM_BTB_ENTRIES - 1; i >= 0; i--) begin
         if (btb_valid[i] && btb_tag[i] == pc_f_i[31:2]) begin
            lk_hit = 1'b1;
            lk_idx = BTB_IDX_W'(i);
         end
         if (btb_valid[i] && btb_tag[i] == branch_source_i[31:2]) begin
            upd_hit = 1'b1;
            upd_idx = BTB_IDX_W'(i);
         end
      end
   end

`ifdef NPC_RAS_EN
   logic        ras_push;
   logic        ras_pop;
   logic [31:0] ras_top;

   assign ras_push = ~flush & (upd_taken | upd_not_taken) & branch_is_call_i;
   assign ras_pop  = ~flush & (upd_taken | upd_not_taken) & branch_is_ret_i & ~branch_is_call_i;

   riscv_npc_ras #(
      .DEPTH (NUM_RAS_ENTRIES)
   ) u_ras (
      .clk_i     (clk_i),
      .flush     (flush),
      .push      (ras_push),
      .push_addr (branch_source_i + 32'd4),
      .pop       (ras_pop),
      .top       (ras_top)
   );
`else
   localparam int unused_ras_depth = NUM_RAS_ENTRIES;
`endif

   // Predictor state may be stale before the first reset edge, so reset masks hits.
   always_comb begin
      pred_taken  = 1'b0;
      pred_target = seq_pc;
      if (!rst_i && lk_hit) begin
         case (btb_type[lk_idx])
            BTB_CALL, BTB_JMP: begin
               pred_taken  = 1'b1;
               pred_target = btb_target[lk_idx];
            end
            BTB_COND: begin
               pred_taken  = bht[lk_bht_idx][1];
               pred_target = btb_target[lk_idx];
            end
            BTB_RET: begin
               pred_taken  = 1'b1;
`ifdef NPC_RAS_EN
               pred_target = ras_top;
`else
               pred_target = btb_target[lk_idx];
`endif
            end
            default: ;
         endcase
      end
   end

   assign next_taken_f_o = pred_taken;
   assign next_pc_f_o    = pred_taken ? pred_target : seq_pc;

   always_ff @(posedge clk_i) begin
      if (flush) begin
         btb_valid <= '0;
         alloc_ptr <= '0;
         for (int i = 0; i < NUM_BHT_ENTRIES; i++) begin
            bht[i] <= BHT_INIT;
         end
      end else if (upd_taken) begin
         if (bht[upd_bht_idx] != 2'b11) begin
            bht[upd_bht_idx] <= bht[upd_bht_idx] + 2'b01;
         end
         if (!upd_hit) begin
            btb_valid[alloc_ptr] <= 1'b1;
            alloc_ptr            <= alloc_ptr + BTB_IDX_W'(1);
         end
      end else if (upd_not_taken) begin
         if (bht[upd_bht_idx] != 2'b00) begin
            bht[upd_bht_idx] <= bht[upd_bht_idx] - 2'b01;
         end
      end
   end

   // Entry payload carries no reset; the valid bits alone gate it.
   always_ff @(posedge clk_i) begin
      if (!flush && upd_taken) begin
         btb_tag[wr_idx]    <= branch_source_i[31:2];
         btb_target[wr_idx] <= branch_pc_i;
         btb_type[wr_idx]   <= upd_type;
      end
   end

endmodule
